// File: rtl/stack_host.sv
// stack_host
// Bus-master front end for an 8-bit bidirectional-bus stack. Turns a
// valid/ready command stream (push with data, or pop) into sequenced stack
// bus cycles with a tri-state turnaround on either side of each read, and
// answers every accepted command with a one-cycle response strobe.
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   cmd_valid/cmd_ready      command handshake (accept on valid & ready)
//   cmd_op, cmd_data         0 = push cmd_data, 1 = pop
//   rsp_valid, rsp_err       response strobe, err = command rejected
//   rsp_data                 last popped value
//   level                    host-tracked stack occupancy
//   stk_push_pop, stk_enable stack control (0 = push / host drives bus)
//   stk_data_io              shared bidirectional data bus
//   stk_empty, stk_full      stack status, sampled only at the accept edge
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a command, bus released
// PUSH      | strobe a write, host drives latched data, push response
// TURN_RD   | direction flipped to read, bus released for one cycle
// POP       | strobe a read
// CAPTURE   | stack drives the bus, sampled into rsp_data at closing edge
// TURN_WR   | direction back to write, pop response
// ERR       | command rejected on full/empty, error response
module stack_host #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int LVL_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic [LVL_W-1:0]  level,
    output logic              stk_push_pop,
    output logic              stk_enable,
    inout  wire  [DATA_W-1:0] stk_data_io,
    input  logic              stk_empty,
    input  logic              stk_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_TURN_RD,
        S_POP,
        S_CAPTURE,
        S_TURN_WR,
        S_ERR
    } state_t;

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic              bus_drive;
    logic [DATA_W-1:0] wr_data;

    assign accept = cmd_valid & cmd_ready;

    // Host owns the bus only while a write strobe is on it.
    assign stk_data_io = bus_drive ? wr_data : {DATA_W{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!cmd_op) begin
                        state_nx = stk_full ? S_ERR : S_PUSH;
                    end else begin
                        state_nx = stk_empty ? S_ERR : S_TURN_RD;
                    end
                end
            end
            S_PUSH:    state_nx = S_IDLE;
            S_TURN_RD: state_nx = S_POP;
            S_POP:     state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_TURN_WR;
            S_TURN_WR: state_nx = S_IDLE;
            S_ERR:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Outputs are flopped from the next state so they line up with the
    // state register and never glitch on multi-bit state changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready    <= 1'b1;
            stk_enable   <= 1'b0;
            stk_push_pop <= 1'b0;
            bus_drive    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            cmd_ready    <= (state_nx == S_IDLE);
            stk_enable   <= (state_nx == S_PUSH) || (state_nx == S_POP);
            stk_push_pop <= (state_nx == S_TURN_RD) || (state_nx == S_POP) ||
                            (state_nx == S_CAPTURE);
            bus_drive    <= (state_nx == S_PUSH);
            rsp_valid    <= (state_nx == S_PUSH) || (state_nx == S_TURN_WR) ||
                            (state_nx == S_ERR);
            rsp_err      <= (state_nx == S_ERR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_data  <= '0;
            rsp_data <= '0;
            level    <= '0;
        end else begin
            if (accept && !cmd_op) begin
                wr_data <= cmd_data;
            end
            if (state == S_CAPTURE) begin
                rsp_data <= stk_data_io;
            end
            // Level follows the stack at the closing edge of each strobe and
            // saturates rather than wrapping.
            if (state == S_PUSH && level != LVL_MAX) begin
                level <= level + 1'b1;
            end else if (state == S_POP && level != '0) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_host.sv
module tb_stack_host;

    localparam int DEPTH = 1024;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_err;
    logic [7:0] rsp_data;
    logic [10:0] level;
    logic       stk_push_pop;
    logic       stk_enable;
    wire  [7:0] stk_data_io;
    logic       stk_empty;
    logic       stk_full;

    stack_host #(.DATA_W(8), .DEPTH(DEPTH), .LVL_W(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_data     (rsp_data),
        .level        (level),
        .stk_push_pop (stk_push_pop),
        .stk_enable   (stk_enable),
        .stk_data_io  (stk_data_io),
        .stk_empty    (stk_empty),
        .stk_full     (stk_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] bus_z = 8'bzzzzzzzz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stack on the far side of the bus. It drives the bus only
    // in the cycle after a read strobe, so any host drive elsewhere shows.
    logic [7:0] smem [DEPTH];
    int         sp = 0;
    logic [7:0] sout = 8'h00;
    logic       sdrv = 1'b0;
    int         strobe_cnt = 0;

    assign stk_data_io = (sdrv && stk_push_pop) ? sout : 8'bzzzzzzzz;
    assign stk_empty   = (sp == 0);
    assign stk_full    = (sp == DEPTH);

    always @(posedge clk) begin
        if (stk_enable) begin
            strobe_cnt <= strobe_cnt + 1;
            if (!stk_push_pop) begin
                if (sp < DEPTH) begin
                    smem[sp] <= stk_data_io;
                    sp <= sp + 1;
                end
                sdrv <= 1'b0;
            end else begin
                if (sp > 0) begin
                    sout <= smem[sp-1];
                    sp <= sp - 1;
                end
                sdrv <= 1'b1;
            end
        end else begin
            sdrv <= 1'b0;
        end
    end

    // Reference model and response scoreboard.
    typedef struct {
        logic       err;
        logic [7:0] data;
        int         acc;
        int         lat;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] ref_q [$];
    logic [7:0] last_data = 8'h00;
    logic [7:0] last_push = 8'h00;

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                check("rsp_latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    // Bus ownership and direction-change checker.
    logic prev_pp = 1'b0;
    logic prev_en = 1'b0;
    logic prev_rst = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            if (stk_enable && !stk_push_pop) begin
                check("bus_push", {24'd0, stk_data_io}, {24'd0, last_push});
            end else if (!sdrv) begin
                check("bus_z", {24'd0, stk_data_io}, {24'd0, bus_z});
            end
            if (!prev_rst && (stk_push_pop !== prev_pp)) begin
                check("pp_toggle_en", {30'd0, prev_en, stk_enable}, 32'd0);
            end
        end
        prev_pp  <= stk_push_pop;
        prev_en  <= stk_enable;
        prev_rst <= rst;
    end

    // Called at a negedge with the host ready; returns at a negedge once the
    // host is ready again.
    task automatic do_cmd(input logic op, input logic [7:0] d);
        int   n;
        int   s0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.err = 1'b0;
        if (!op) begin
            if (ref_q.size() == DEPTH) begin
                e.err = 1'b1;
            end else begin
                ref_q.push_back(d);
                last_push = d;
            end
        end else begin
            if (ref_q.size() == 0) begin
                e.err = 1'b1;
            end else begin
                last_data = ref_q.pop_back();
            end
        end
        e.data = last_data;
        e.acc  = cyc + 1;
        e.lat  = (op && !e.err) ? 4 : 1;
        sb.push_back(e);
        s0 = strobe_cnt;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        cmd_data  = 8'($urandom);
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("done_timeout", 32'd0, 32'd1);
        check("level", {21'd0, level}, ref_q.size());
        check("strobes", strobe_cnt - s0, e.err ? 0 : 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_enable"},   {31'd0, stk_enable},   32'd0);
        check({tag, "_push_pop"}, {31'd0, stk_push_pop}, 32'd0);
        check({tag, "_bus"},      {24'd0, stk_data_io},  {24'd0, bus_z});
        check({tag, "_rsp_valid"},{31'd0, rsp_valid},    32'd0);
        check({tag, "_rsp_err"},  {31'd0, rsp_err},      32'd0);
        check({tag, "_rsp_data"}, {24'd0, rsp_data},     32'd0);
        check({tag, "_level"},    {21'd0, level},        32'd0);
        check({tag, "_ready"},    {31'd0, cmd_ready},    32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_data  = 8'h00;

        #25;
        check_reset_state("reset");
        #5;
        rst = 1'b0;
        @(negedge clk);

        // Three pushes then LIFO readback.
        do_cmd(1'b0, 8'h00);
        do_cmd(1'b0, 8'h02);
        do_cmd(1'b0, 8'h04);
        check("level_after_3", {21'd0, level}, 32'd3);
        for (int i = 0; i < 3; i++) do_cmd(1'b1, 8'h00);
        check("level_after_lifo", {21'd0, level}, 32'd0);

        // Fill to capacity, then one push too many.
        for (int i = 0; i < DEPTH; i++) do_cmd(1'b0, 8'(2 * i));
        check("level_full", {21'd0, level}, DEPTH);
        check("stk_full", {31'd0, stk_full}, 32'd1);
        do_cmd(1'b0, 8'h77);
        check("level_sat_hi", {21'd0, level}, DEPTH);

        // Drain completely, then one pop too many.
        for (int i = 0; i < DEPTH; i++) do_cmd(1'b1, 8'h00);
        check("stk_empty", {31'd0, stk_empty}, 32'd1);
        do_cmd(1'b1, 8'h00);
        check("level_sat_lo", {21'd0, level}, 32'd0);

        // Alternating push/pop to exercise both turnarounds back to back.
        for (int i = 0; i < 16; i++) begin
            do_cmd(1'b0, 8'hA5);
            do_cmd(1'b1, 8'h00);
        end

        // Reset while the stack is driving the bus for a read.
        do_cmd(1'b0, 8'h3C);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        check("midpop_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midpop");
        void'(ref_q.pop_back());
        sb.delete();
        last_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_cmd(1'b0, 8'h5A);
        do_cmd(1'b1, 8'h00);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        check("watchdog", 32'd0, 32'd1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
